bp_cce_lce_req_responder: RTL and testbench
===========================================

# bp_cce_lce_req_responder

Single-request coherence responder sitting at the CCE end of the LCE↔CCE network, servicing instruction-cache read misses. Accepts one LCE miss request, fetches the block from memory, returns it with a data command and a set-tag command, then waits for the LCE's coherence or transfer acknowledgement before accepting the next request. Non-pipelined: exactly one outstanding transaction.

## Interface
Parameters:
- num_cce_p, "inv", number of CCEs; sizes CCE id fields.
- num_lce_p, "inv", number of LCEs; sizes LCE id fields.
- lce_addr_width_p, "inv", physical address width.
- ways_p, "inv", LCE associativity; sizes way_id.
- block_size_in_bytes_p, "inv", cache block size; data payload = block_size_in_bytes_p*8 bits.

Ports (clock and reset first). Reset is asynchronous and active-high; one clock.
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous active-high reset.
- id_i  in  lg(num_cce_p)  this CCE's id; drives src_id of all outgoing commands.
- lce_req_i  in  bp_lce_cce_req_width  miss request (src_id, msg_type, non_exclusive, addr, lru_way_id, lru_dirty).
- lce_req_v_i  in  1  request valid.
- lce_req_ready_o  out  1  ready; transfer when v & ready.
- lce_resp_i  in  bp_lce_cce_resp_width  LCE response (src_id, msg_type, addr).
- lce_resp_v_i  in  1  response valid.
- lce_resp_yumi_o  out  1  response consumed this cycle.
- lce_cmd_o  out  bp_cce_lce_cmd_width  set-tag command.
- lce_cmd_v_o  out  1  command valid.
- lce_cmd_ready_i  in  1  command accepted.
- lce_data_cmd_o  out  bp_cce_lce_data_cmd_width  block data command.
- lce_data_cmd_v_o  out  1  data command valid.
- lce_data_cmd_ready_i  in  1  data command accepted.
- mem_addr_o  out  lce_addr_width_p  block-aligned fetch address.
- mem_v_o  out  1  fetch request valid.
- mem_ready_i  in  1  fetch request accepted.
- mem_data_i  in  block_size_in_bytes_p*8  returned block.
- mem_data_v_i  in  1  returned block valid (single-cycle pulse, no backpressure).
- busy_o  out  1  transaction in flight (state ≠ READY).
- resp_err_o  out  1  one-cycle pulse: consumed response with unexpected msg_type or addr.

## Operation
- States: READY → MEM_REQ → MEM_WAIT → SEND_DATA → SEND_SET_TAG → WAIT_ACK → READY.
- READY: lce_req_ready_o=1. On lce_req_v_i: latch src_id, addr, lru_way_id; go MEM_REQ. msg_type and non_exclusive are not interpreted (read-exclusive service only).
- MEM_REQ: mem_v_o=1, mem_addr_o = latched addr with low lg(block_size_in_bytes_p) bits zeroed. On mem_ready_i → MEM_WAIT.
- MEM_WAIT: on mem_data_v_i capture mem_data_i into block register → SEND_DATA. mem_data_v_i in any other state ignored.
- SEND_DATA: lce_data_cmd_v_o=1; fields: dst_id=latched src_id, way_id=latched lru_way_id, data=block register, msg_type=e_lce_req_type_rd. On lce_data_cmd_ready_i → SEND_SET_TAG.
- SEND_SET_TAG: lce_cmd_v_o=1; fields: dst_id=latched src_id, src_id=id_i, msg_type=e_lce_cmd_set_tag, addr=latched addr, way_id=latched lru_way_id, state=exclusive encoding. On lce_cmd_ready_i → WAIT_ACK.
- WAIT_ACK: lce_resp_yumi_o = lce_resp_v_i. Consumed e_lce_cce_coh_ack or e_lce_cce_tr_ack with addr matching latched addr (block-aligned compare) → READY. Any other consumed response: resp_err_o=1 that cycle, remain WAIT_ACK.
- lce_resp_yumi_o=0 in all states other than WAIT_ACK.
- Outputs lce_cmd_o/lce_data_cmd_o are driven from latched registers and stable while their valid is high.

## Timing
- Reset (asynchronous, immediate): state=READY, all latched registers 0; lce_req_ready_o=1, busy_o=0, mem_v_o=0, lce_cmd_v_o=0, lce_data_cmd_v_o=0, lce_resp_yumi_o=0, resp_err_o=0. Reset mid-transaction abandons it; no partial commands issued afterward.
- Request accepted at edge of cycle 0 → mem_v_o high in cycle 1.
- mem_data_v_i in cycle N → lce_data_cmd_v_o high cycle N+1.
- Minimum request-to-READY: 5 cycles plus memory latency with all readies held high and ack presented immediately.
- Valids stay asserted until their ready; no valid drops without handshake.
- lce_req_ready_o is purely state-decoded (1 only in READY); a request arriving while busy is held off, not dropped.
- Acknowledge consumed in cycle K → lce_req_ready_o=1 in cycle K+1.

## Test plan
- Reset, req addr=0x1234_5678, lru_way=2, src_id=1; mem_ready=1, data 0xA5.. after 3 cycles -> mem_addr_o=0x1234_5640 (64B block), data cmd way=2 dst=1 data=0xA5.., then set_tag addr=0x1234_5678 way=2; coh_ack -> READY.
- Hold lce_data_cmd_ready_i=0 for 4 cycles, then lce_cmd_ready_i=0 for 3 -> valids/payloads stable, each issued exactly once.
- Second request presented during MEM_WAIT -> lce_req_ready_o=0 until cycle after ack; then accepted with its own addr.
- In WAIT_ACK send tr_ack with wrong addr -> yumi, resp_err_o pulse, stay WAIT_ACK; then correct tr_ack -> READY.
- Assert reset_i asynchronously mid-SEND_SET_TAG -> lce_cmd_v_o drops same cycle, busy_o=0, no further commands.
- Spurious lce_resp_v_i in READY and mem_data_v_i in SEND_DATA -> not consumed, block register unchanged.

Source files
------------

// File: rtl/bp_cce_lce_req_responder.sv
// CCE-side responder that services one LCE instruction-miss request at a time:
// fetch the block from memory, send data and set-tag commands, then wait for the LCE ack.
//
// Message layouts (MSB first):
//   lce_req      : {src_id, msg_type(1), non_exclusive(1), addr, lru_way_id, lru_dirty(1)}
//   lce_resp     : {src_id, msg_type(2), addr}
//   lce_cmd      : {dst_id, src_id(cce), msg_type(4), addr, way_id, state(2)}
//   lce_data_cmd : {dst_id, msg_type(1), way_id, data}
module bp_cce_lce_req_responder #(
    parameter int unsigned num_cce_p             = 2,
    parameter int unsigned num_lce_p             = 4,
    parameter int unsigned lce_addr_width_p      = 32,
    parameter int unsigned ways_p                = 8,
    parameter int unsigned block_size_in_bytes_p = 64,
    localparam int unsigned cce_id_w   = (num_cce_p > 1) ? $clog2(num_cce_p) : 1,
    localparam int unsigned lce_id_w   = (num_lce_p > 1) ? $clog2(num_lce_p) : 1,
    localparam int unsigned way_w      = (ways_p > 1) ? $clog2(ways_p) : 1,
    localparam int unsigned data_w     = block_size_in_bytes_p * 8,
    localparam int unsigned req_w      = lce_id_w + 3 + lce_addr_width_p + way_w,
    localparam int unsigned resp_w     = lce_id_w + 2 + lce_addr_width_p,
    localparam int unsigned cmd_w      = lce_id_w + cce_id_w + 4 + lce_addr_width_p + way_w + 2,
    localparam int unsigned data_cmd_w = lce_id_w + 1 + way_w + data_w
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic [cce_id_w-1:0]         id_i,
    input  logic [req_w-1:0]            lce_req_i,
    input  logic                        lce_req_v_i,
    output logic                        lce_req_ready_o,
    input  logic [resp_w-1:0]           lce_resp_i,
    input  logic                        lce_resp_v_i,
    output logic                        lce_resp_yumi_o,
    output logic [cmd_w-1:0]            lce_cmd_o,
    output logic                        lce_cmd_v_o,
    input  logic                        lce_cmd_ready_i,
    output logic [data_cmd_w-1:0]       lce_data_cmd_o,
    output logic                        lce_data_cmd_v_o,
    input  logic                        lce_data_cmd_ready_i,
    output logic [lce_addr_width_p-1:0] mem_addr_o,
    output logic                        mem_v_o,
    input  logic                        mem_ready_i,
    input  logic [data_w-1:0]           mem_data_i,
    input  logic                        mem_data_v_i,
    output logic                        busy_o,
    output logic                        resp_err_o
);

    localparam logic [1:0] e_lce_cce_coh_ack  = 2'd2;
    localparam logic [1:0] e_lce_cce_tr_ack   = 2'd3;
    localparam logic [3:0] e_lce_cmd_set_tag  = 4'd4;
    localparam logic [1:0] e_mesi_exclusive   = 2'd2;
    localparam logic       e_lce_req_type_rd  = 1'b0;

    localparam logic [lce_addr_width_p-1:0] blk_mask =
        ~(lce_addr_width_p'(block_size_in_bytes_p - 1));

    typedef enum logic [2:0] {
        e_ready,
        e_mem_req,
        e_mem_wait,
        e_send_data,
        e_send_set_tag,
        e_wait_ack
    } state_e;

    state_e state_r, state_n;

    logic [lce_id_w-1:0]         src_r;
    logic [lce_addr_width_p-1:0] addr_r;
    logic [way_w-1:0]            way_r;
    logic [data_w-1:0]           block_r;

    logic [lce_id_w-1:0]         req_src;
    logic [lce_addr_width_p-1:0] req_addr;
    logic [way_w-1:0]            req_way;
    logic [1:0]                  resp_type;
    logic [lce_addr_width_p-1:0] resp_addr;
    logic                        ack_ok;

    assign req_src   = lce_req_i[req_w-1 -: lce_id_w];
    assign req_addr  = lce_req_i[way_w+1 +: lce_addr_width_p];
    assign req_way   = lce_req_i[1 +: way_w];
    assign resp_type = lce_resp_i[lce_addr_width_p +: 2];
    assign resp_addr = lce_resp_i[lce_addr_width_p-1:0];

    // Request type/exclusivity, dirty bit and responder id are not interpreted.
    logic unused;
    assign unused = ^{lce_req_i[req_w-lce_id_w-1 -: 2], lce_req_i[0],
                      lce_resp_i[resp_w-1 -: lce_id_w]};

    assign ack_ok = ((resp_type == e_lce_cce_coh_ack) || (resp_type == e_lce_cce_tr_ack))
                    && ((resp_addr & blk_mask) == (addr_r & blk_mask));

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= e_ready;
        end else begin
            state_r <= state_n;
        end
    end

    // Transaction context and fetched block.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            src_r   <= '0;
            addr_r  <= '0;
            way_r   <= '0;
            block_r <= '0;
        end else begin
            if (state_r == e_ready && lce_req_v_i) begin
                src_r  <= req_src;
                addr_r <= req_addr;
                way_r  <= req_way;
            end
            if (state_r == e_mem_wait && mem_data_v_i) begin
                block_r <= mem_data_i;
            end
        end
    end

    always_comb begin
        state_n          = state_r;
        lce_req_ready_o  = 1'b0;
        mem_v_o          = 1'b0;
        lce_data_cmd_v_o = 1'b0;
        lce_cmd_v_o      = 1'b0;
        lce_resp_yumi_o  = 1'b0;
        resp_err_o       = 1'b0;
        unique case (state_r)
            e_ready: begin
                lce_req_ready_o = 1'b1;
                if (lce_req_v_i) state_n = e_mem_req;
            end
            e_mem_req: begin
                mem_v_o = 1'b1;
                if (mem_ready_i) state_n = e_mem_wait;
            end
            e_mem_wait: begin
                if (mem_data_v_i) state_n = e_send_data;
            end
            e_send_data: begin
                lce_data_cmd_v_o = 1'b1;
                if (lce_data_cmd_ready_i) state_n = e_send_set_tag;
            end
            e_send_set_tag: begin
                lce_cmd_v_o = 1'b1;
                if (lce_cmd_ready_i) state_n = e_wait_ack;
            end
            e_wait_ack: begin
                // Every response is consumed; only a matching ack closes the transaction.
                lce_resp_yumi_o = lce_resp_v_i;
                if (lce_resp_v_i) begin
                    if (ack_ok) state_n = e_ready;
                    else        resp_err_o = 1'b1;
                end
            end
            default: state_n = e_ready;
        endcase
    end

    assign busy_o         = (state_r != e_ready);
    assign mem_addr_o     = addr_r & blk_mask;
    assign lce_cmd_o      = {src_r, id_i, e_lce_cmd_set_tag, addr_r, way_r, e_mesi_exclusive};
    assign lce_data_cmd_o = {src_r, e_lce_req_type_rd, way_r, block_r};

endmodule

// File: tb/tb_bp_cce_lce_req_responder.sv
// Directed bench for bp_cce_lce_req_responder with a transaction-level reference model
// checked every cycle, plus literal expectations on key fields and timings.
module tb_bp_cce_lce_req_responder;

    localparam int unsigned NCCE  = 2;
    localparam int unsigned NLCE  = 4;
    localparam int unsigned AW    = 32;
    localparam int unsigned WAYS  = 8;
    localparam int unsigned BS    = 64;
    localparam int unsigned DW    = 512;
    localparam int unsigned REQW  = 40;
    localparam int unsigned RESPW = 36;
    localparam int unsigned CMDW  = 44;
    localparam int unsigned DCMDW = 518;
    localparam logic [31:0] MASK  = 32'hFFFF_FFC0;

    logic             clk, reset_i;
    logic [0:0]       id_i;
    logic [REQW-1:0]  lce_req_i;
    logic             lce_req_v_i, lce_req_ready_o;
    logic [RESPW-1:0] lce_resp_i;
    logic             lce_resp_v_i, lce_resp_yumi_o;
    logic [CMDW-1:0]  lce_cmd_o;
    logic             lce_cmd_v_o, lce_cmd_ready_i;
    logic [DCMDW-1:0] lce_data_cmd_o;
    logic             lce_data_cmd_v_o, lce_data_cmd_ready_i;
    logic [AW-1:0]    mem_addr_o;
    logic             mem_v_o, mem_ready_i;
    logic [DW-1:0]    mem_data_i;
    logic             mem_data_v_i;
    logic             busy_o, resp_err_o;

    bp_cce_lce_req_responder #(
        .num_cce_p(NCCE), .num_lce_p(NLCE), .lce_addr_width_p(AW),
        .ways_p(WAYS), .block_size_in_bytes_p(BS)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .id_i(id_i),
        .lce_req_i(lce_req_i), .lce_req_v_i(lce_req_v_i), .lce_req_ready_o(lce_req_ready_o),
        .lce_resp_i(lce_resp_i), .lce_resp_v_i(lce_resp_v_i), .lce_resp_yumi_o(lce_resp_yumi_o),
        .lce_cmd_o(lce_cmd_o), .lce_cmd_v_o(lce_cmd_v_o), .lce_cmd_ready_i(lce_cmd_ready_i),
        .lce_data_cmd_o(lce_data_cmd_o), .lce_data_cmd_v_o(lce_data_cmd_v_o),
        .lce_data_cmd_ready_i(lce_data_cmd_ready_i),
        .mem_addr_o(mem_addr_o), .mem_v_o(mem_v_o), .mem_ready_i(mem_ready_i),
        .mem_data_i(mem_data_i), .mem_data_v_i(mem_data_v_i),
        .busy_o(busy_o), .resp_err_o(resp_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [599:0] act, input logic [599:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Transaction-level model: which step of the current miss is still outstanding.
    bit          in_txn = 0, fetched = 0, have_data = 0, data_sent = 0, cmd_sent = 0;
    logic [1:0]  cur_src = '0;
    logic [31:0] cur_addr = '0;
    logic [2:0]  cur_way = '0;
    logic [DW-1:0] exp_block = '0;
    int obs_data_hs = 0, obs_cmd_hs = 0;

    function automatic bit ack_good(input logic [1:0] t, input logic [31:0] a,
                                    input logic [31:0] ref_a);
        return ((t == 2'd2) || (t == 2'd3)) && ((a & MASK) == (ref_a & MASK));
    endfunction

    always @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            in_txn <= 0; fetched <= 0; have_data <= 0; data_sent <= 0; cmd_sent <= 0;
        end else begin
            if (lce_data_cmd_v_o && lce_data_cmd_ready_i) obs_data_hs <= obs_data_hs + 1;
            if (lce_cmd_v_o && lce_cmd_ready_i) obs_cmd_hs <= obs_cmd_hs + 1;
            if (!in_txn) begin
                if (lce_req_v_i) begin
                    in_txn <= 1; fetched <= 0; have_data <= 0; data_sent <= 0; cmd_sent <= 0;
                    cur_src  <= lce_req_i[39:38];
                    cur_addr <= lce_req_i[35:4];
                    cur_way  <= lce_req_i[3:1];
                end
            end else if (!fetched) begin
                if (mem_ready_i) fetched <= 1;
            end else if (!have_data) begin
                if (mem_data_v_i) begin
                    have_data <= 1;
                    exp_block <= mem_data_i;
                end
            end else if (!data_sent) begin
                if (lce_data_cmd_ready_i) data_sent <= 1;
            end else if (!cmd_sent) begin
                if (lce_cmd_ready_i) cmd_sent <= 1;
            end else if (lce_resp_v_i && ack_good(lce_resp_i[33:32], lce_resp_i[31:0], cur_addr)) begin
                in_txn <= 0;
            end
        end
    end

    logic [6:0] exp_ctrl, act_ctrl;
    logic       exp_yumi;

    always @(negedge clk) begin
        exp_yumi = in_txn && cmd_sent && lce_resp_v_i;
        exp_ctrl = {!in_txn, in_txn, in_txn && !fetched,
                    in_txn && have_data && !data_sent,
                    in_txn && data_sent && !cmd_sent,
                    exp_yumi,
                    exp_yumi && !ack_good(lce_resp_i[33:32], lce_resp_i[31:0], cur_addr)};
        act_ctrl = {lce_req_ready_o, busy_o, mem_v_o, lce_data_cmd_v_o, lce_cmd_v_o,
                    lce_resp_yumi_o, resp_err_o};
        chk("ctrl{rdy,busy,memv,dv,cv,yumi,err}", 600'(act_ctrl), 600'(exp_ctrl));
        if (in_txn && !fetched)
            chk("mem_addr", 600'(mem_addr_o), 600'(cur_addr & MASK));
        if (in_txn && have_data && !data_sent)
            chk("data_cmd", 600'(lce_data_cmd_o), 600'({cur_src, 1'b0, cur_way, exp_block}));
        if (in_txn && data_sent && !cmd_sent)
            chk("set_tag_cmd", 600'(lce_cmd_o),
                600'({cur_src, id_i, 4'd4, cur_addr, cur_way, 2'd2}));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns at the negedge where the selected output is high.
    task automatic wait_sig(input int which, input string name);
        bit hit;
        hit = 0;
        for (int n = 0; n < 200 && !hit; n++) begin
            @(negedge clk);
            case (which)
                0: hit = mem_v_o;
                1: hit = lce_data_cmd_v_o;
                2: hit = lce_cmd_v_o;
                default: hit = lce_resp_yumi_o;
            endcase
        end
        if (!hit) chk({name, "_timeout"}, 600'(0), 600'(1));
    endtask

    task automatic send_req(input logic [1:0] src, input logic [31:0] addr, input logic [2:0] way);
        bit hit;
        hit = 0;
        lce_req_i   = {src, 1'b0, 1'b0, addr, way, 1'b0};
        lce_req_v_i = 1'b1;
        for (int n = 0; n < 200 && !hit; n++) begin
            @(negedge clk);
            hit = lce_req_ready_o;
        end
        if (!hit) chk("req_timeout", 600'(0), 600'(1));
        tick();
        lce_req_v_i = 1'b0;
    endtask

    task automatic do_mem(input int lat, input logic [DW-1:0] blk);
        wait_sig(0, "mem_v");
        tick();
        repeat (lat - 1) tick();
        mem_data_i   = blk;
        mem_data_v_i = 1'b1;
        tick();
        mem_data_v_i = 1'b0;
    endtask

    task automatic ack(input logic [1:0] t, input logic [31:0] a);
        lce_resp_i   = {2'b00, t, a};
        lce_resp_v_i = 1'b1;
        wait_sig(3, "ack");
        tick();
        lce_resp_v_i = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    logic [DCMDW-1:0] dc;
    logic [CMDW-1:0]  cc;
    int d0, c0;

    initial begin
        reset_i = 1'b1; id_i = 1'b1;
        lce_req_i = '0; lce_req_v_i = 0; lce_resp_i = '0; lce_resp_v_i = 0;
        lce_cmd_ready_i = 1; lce_data_cmd_ready_i = 1; mem_ready_i = 1;
        mem_data_i = '0; mem_data_v_i = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", 600'({lce_req_ready_o, busy_o, mem_v_o, lce_cmd_v_o,
                                   lce_data_cmd_v_o, lce_resp_yumi_o, resp_err_o}),
            600'(7'b1000000));
        chk("reset_data_cmd_zero", 600'(lce_data_cmd_o), 600'(0));
        tick();
        reset_i = 1'b0;

        // Basic miss: fetch address, data command, set-tag command, coh_ack.
        send_req(2'd1, 32'h1234_5678, 3'd2);
        chk("lat_mem_v_next_cycle", 600'(mem_v_o), 600'(1));
        chk("mem_addr_aligned", 600'(mem_addr_o), 600'(32'h1234_5640));
        do_mem(3, {64{8'hA5}});
        wait_sig(1, "data_v");
        dc = lce_data_cmd_o;
        chk("data_dst", 600'(dc[517:516]), 600'(2'd1));
        chk("data_way", 600'(dc[514:512]), 600'(3'd2));
        chk("data_block", 600'(dc[511:0]), 600'({64{8'hA5}}));
        tick();
        wait_sig(2, "cmd_v");
        cc = lce_cmd_o;
        chk("tag_addr", 600'(cc[36:5]), 600'(32'h1234_5678));
        chk("tag_way", 600'(cc[4:2]), 600'(3'd2));
        chk("tag_type_state", 600'({cc[40:37], cc[1:0]}), 600'({4'd4, 2'd2}));
        tick();
        ack(2'd2, 32'h1234_5678);
        chk("ready_after_ack", 600'(lce_req_ready_o), 600'(1));

        // Backpressure on both command channels.
        d0 = obs_data_hs; c0 = obs_cmd_hs;
        lce_data_cmd_ready_i = 0; lce_cmd_ready_i = 0;
        send_req(2'd3, 32'h8000_00FF, 3'd5);
        do_mem(1, {64{8'h1F}});
        wait_sig(1, "data_v");
        repeat (4) tick();
        chk("data_v_held", 600'(lce_data_cmd_v_o), 600'(1));
        lce_data_cmd_ready_i = 1;
        tick();
        lce_data_cmd_ready_i = 0;
        wait_sig(2, "cmd_v");
        repeat (3) tick();
        chk("cmd_v_held", 600'(lce_cmd_v_o), 600'(1));
        lce_cmd_ready_i = 1;
        tick();
        lce_data_cmd_ready_i = 1;
        ack(2'd3, 32'h8000_00C0);
        chk("data_issued_once", 600'(obs_data_hs - d0), 600'(1));
        chk("cmd_issued_once", 600'(obs_cmd_hs - c0), 600'(1));

        // Second request held off while the first is in flight.
        send_req(2'd0, 32'h0000_1000, 3'd1);
        wait_sig(0, "mem_v");
        tick();
        fork
            send_req(2'd2, 32'h4444_4444, 3'd7);
            begin
                chk("held_off_in_mem_wait", 600'(lce_req_ready_o), 600'(0));
                tick();
                mem_data_i = {64{8'hC3}}; mem_data_v_i = 1;
                tick();
                mem_data_v_i = 0;
                wait_sig(1, "data_v"); tick();
                wait_sig(2, "cmd_v");  tick();
                ack(2'd2, 32'h0000_1010);
                chk("ready_cycle_after_ack", 600'(lce_req_ready_o), 600'(1));
            end
        join
        chk("second_req_mem_v", 600'(mem_v_o), 600'(1));
        chk("second_req_addr", 600'(mem_addr_o), 600'(32'h4444_4440));

        // Bad acks: next block address, then wrong message type; then in-block tr_ack.
        do_mem(2, {64{8'h96}});
        wait_sig(1, "data_v"); tick();
        wait_sig(2, "cmd_v");  tick();
        lce_resp_i = {2'b00, 2'd3, 32'h4444_4480}; lce_resp_v_i = 1;
        wait_sig(3, "bad_addr_yumi");
        chk("err_wrong_addr", 600'(resp_err_o), 600'(1));
        tick();
        lce_resp_v_i = 0;
        @(negedge clk);
        chk("stay_after_bad_ack", 600'({busy_o, resp_err_o}), 600'(2'b10));
        lce_resp_i = {2'b00, 2'd1, 32'h4444_4444}; lce_resp_v_i = 1;
        wait_sig(3, "bad_type_yumi");
        chk("err_wrong_type", 600'(resp_err_o), 600'(1));
        tick();
        lce_resp_v_i = 0;
        ack(2'd3, 32'h4444_4443);
        chk("ready_after_tr_ack", 600'(lce_req_ready_o), 600'(1));

        // Spurious response in READY and spurious memory data in SEND_DATA.
        lce_resp_i = {2'b00, 2'd2, 32'h0}; lce_resp_v_i = 1;
        repeat (3) begin
            @(negedge clk);
            chk("no_yumi_in_ready", 600'(lce_resp_yumi_o), 600'(0));
        end
        tick();
        lce_resp_v_i = 0;
        lce_data_cmd_ready_i = 0;
        send_req(2'd1, 32'h0000_2000, 3'd3);
        do_mem(1, {64{8'h5A}});
        wait_sig(1, "data_v");
        mem_data_i = {64{8'h3C}}; mem_data_v_i = 1;
        tick();
        mem_data_v_i = 0;
        @(negedge clk);
        dc = lce_data_cmd_o;
        chk("block_unchanged", 600'(dc[511:0]), 600'({64{8'h5A}}));
        lce_data_cmd_ready_i = 1;
        tick();
        wait_sig(2, "cmd_v"); tick();
        ack(2'd2, 32'h0000_2000);

        // Asynchronous reset while the set-tag command is pending.
        lce_cmd_ready_i = 0;
        send_req(2'd0, 32'h0000_3000, 3'd4);
        do_mem(1, {64{8'h77}});
        wait_sig(1, "data_v"); tick();
        wait_sig(2, "cmd_v");
        d0 = obs_data_hs; c0 = obs_cmd_hs;
        @(posedge clk);
        #3;
        reset_i = 1;
        #1;
        chk("async_reset_outputs", 600'({lce_cmd_v_o, busy_o, lce_req_ready_o}), 600'(3'b001));
        tick(); tick();
        reset_i = 0;
        lce_cmd_ready_i = 1; lce_data_cmd_ready_i = 1;
        repeat (6) tick();
        chk("no_cmd_after_reset", 600'({obs_cmd_hs - c0, obs_data_hs - d0}), 600'(0));
        chk("idle_after_reset", 600'(busy_o), 600'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
